mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Multi-cycle physical memory controller directly downstream of the TLB/address-decode stage. Takes the translated physical address and the single-hot device select (SRAM, flash, boot ROM, serial) from that stage together with the MEM-stage request. Runs one access at a time through a wait-state FSM and stalls the pipeline until the access completes. Drives the external SRAM and flash pins, the on-chip ROM port and the UART strobes.

## Interface
- SRAM_WAIT, 1: extra SRAM cycles after the first access cycle (0–7)
- FLASH_WAIT, 4: cycles per 16-bit flash read (1–15)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_i  in  1  MEM-stage load/store valid; held stable until ready_o
- we_i  in  1  1 = store
- sel_i  in  4  byte enables
- addr_i  in  32  physical address (TLB addr_o)
- data_i  in  32  store data
- tlb_hit_i, sram_ce_i, flash_ce_i, rom_ce_i, serial_ce_i  in  1 each  from TLB stage
- data_o  out  32  load data, held until next accepted request
- ready_o  out  1  one-cycle completion pulse
- stall_req_o  out  1  pipeline stall request
- tlb_miss_o  out  1  request with tlb_hit_i=0
- sram_addr_o  out  20  word address = addr_i[21:2]
- sram_wdata_o  out  32; sram_rdata_i  in  32
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each; sram_be_n  out  4
- flash_addr_o  out  23; flash_rdata_i  in  16; flash_ce_n, flash_oe_n  out  1 each
- rom_addr_o  out  10 (addr_i[11:2]); rom_data_i  in  32 (synchronous, 1-cycle)
- uart_wdata_o  out  8; uart_rdata_i  in  8; uart_rd_o, uart_wr_o  out  1 each
- uart_rx_ready_i, uart_tx_busy_i  in  1 each

## Operation
- States: IDLE, SRAM, FLASH_LO, FLASH_HI, ROM, UART, DONE. A 4-bit wait counter is loaded on every state entry.
- IDLE with req_i=1:
  - tlb_hit_i=0: tlb_miss_o=1 combinationally, no stall, stay in IDLE.
  - sram_ce_i → SRAM.
  - flash_ce_i → FLASH_LO.
  - rom_ce_i → ROM.
  - serial_ce_i → UART.
  - no ce asserted → DONE with data_o=0.
- Accepting a request latches addr_i, data_i, sel_i and we_i into internal registers. req_i is ignored outside IDLE.
- SRAM: held for SRAM_WAIT+1 cycles.
  - ce_n=0 throughout.
  - Read: oe_n=0, data_o samples sram_rdata_i on the last cycle.
  - Write: we_n=0 on all cycles except the last (data hold), be_n=~sel.
  - Then DONE.
- FLASH (read-only):
  - FLASH_LO for FLASH_WAIT cycles at flash_addr_o={addr[22:2],2'b00}, then latch data_o[15:0].
  - FLASH_HI for FLASH_WAIT cycles at {addr[22:2],2'b10}, then latch data_o[31:16].
  - Stores complete via DONE with no pin activity.
- ROM: one cycle. data_o=rom_data_i. Stores are ignored. Then DONE.
- UART: one cycle at physical 0x1FD003F8 (data) or 0x1FD003FC (status).
  - Data read: uart_rd_o pulse, data_o={24'b0,uart_rdata_i}.
  - Data write: uart_wr_o pulse, uart_wdata_o=data[7:0].
  - Status read: data_o={30'b0, uart_rx_ready_i, ~uart_tx_busy_i}.
  - Status write: ignored.
- DONE: ready_o=1, then IDLE.

## Timing
- stall_req_o = (IDLE & req_i & tlb_hit_i) | (state ∉ {IDLE, DONE}). It is low in DONE, so the pipeline advances on the DONE edge.
- Latency from acceptance cycle 0 to the ready_o cycle:
  - SRAM: SRAM_WAIT+2.
  - Flash: 2·FLASH_WAIT+1.
  - ROM: 2.
  - UART: 2.
  - No device: 1.
- A back-to-back request is accepted in the IDLE cycle after DONE. There is no overlap.
- Reset values:
  - state IDLE.
  - data_o=0, ready_o=0, stall_req_o=0, tlb_miss_o=0.
  - All *_n = 1.
  - uart_rd_o=0, uart_wr_o=0.
  - Addresses and wdata = 0.
- rst asserted mid-access: IDLE on that edge, all strobes inactive, no ready_o pulse. The access is abandoned.
- Counter is 4 bits with no wrap: the parameter ranges above are enforced.

## Configuration
- MEM_CTRL_FLASH_EN defined: flash path as described.
- Undefined:
  - FLASH_LO and FLASH_HI are not built.
  - flash_ce_i requests behave as "no device" (DONE, data_o=0, latency 1).
  - flash_ce_n=1 and flash_oe_n=1 constantly.

## Structure
- defines.v holds:
  - RegBus, ZeroWord, RstEnable, WriteEnable.
  - New state encodings MEMCTL_IDLE..MEMCTL_DONE (3-bit).
  - UART_DATA_PADDR = 32'h1FD003F8 and UART_STAT_PADDR = 32'h1FD003FC.
- One sub-module, mem_wait_cnt: loadable 4-bit down-counter with a zero flag, shared by all wait states.

## Test plan
- SRAM read, SRAM_WAIT=1, addr 0x00000100, sram_rdata_i=0xDEADBEEF → sram_addr_o=0x40, oe_n low 2 cycles, ready_o at cycle 3, data_o=0xDEADBEEF, stall low on cycle 3.
- SRAM store sel=4'b0011, data 0x12345678 → be_n=4'b1100, we_n low 1 cycle then high, ready_o at cycle 3.
- Flash read (macro on, FLASH_WAIT=4):
  - Stimulus: halves 0xBEEF then 0xCAFE at addr 0x1E000004.
  - Response: flash_addr_o 0x000004 then 0x000006, data_o=0xCAFEBEEF, ready_o at cycle 9.
  - Macro off: ready_o at cycle 1, data_o=0.
- UART:
  - Status read with rx_ready=1, tx_busy=1 → data_o=0x00000002.
  - Data write 0x41 → single uart_wr_o pulse, uart_wdata_o=0x41.
- req_i with tlb_hit_i=0 → tlb_miss_o=1, stall_req_o=0, state stays IDLE.
- rst during second SRAM cycle → next cycle IDLE, sram_ce_n=1, no ready_o.
- Subsequent ROM read: ready_o at cycle 2 with rom_data_i.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the physical memory controller.
// State encodings, register-bus constants and UART physical addresses.
package mem_ctrl_pkg;

    localparam int          RegBus      = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    localparam logic [31:0] UART_DATA_PADDR = 32'h1FD0_03F8;
    localparam logic [31:0] UART_STAT_PADDR = 32'h1FD0_03FC;

    typedef enum logic [2:0] {
        MEMCTL_IDLE     = 3'd0,
        MEMCTL_SRAM     = 3'd1,
        MEMCTL_FLASH_LO = 3'd2,
        MEMCTL_FLASH_HI = 3'd3,
        MEMCTL_ROM      = 3'd4,
        MEMCTL_UART     = 3'd5,
        MEMCTL_DONE     = 3'd6
    } memctl_state_t;

    function automatic logic [RegBus-1:0] uart_status(
        input logic rx_ready,
        input logic tx_busy
    );
        return {30'b0, rx_ready, ~tx_busy};
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag; holds at zero (no wrap).
// Shared by every wait state of the memory controller.
module mem_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle physical memory controller: SRAM, flash, boot ROM, UART.
// Flash path built only when MEM_CTRL_FLASH_EN is defined.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT  = 1,
    parameter int FLASH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        tlb_hit_i,
    input  logic        sram_ce_i,
    input  logic        flash_ce_i,
    input  logic        rom_ce_i,
    input  logic        serial_ce_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stall_req_o,
    output logic        tlb_miss_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n,
    output logic [22:0] flash_addr_o,
    input  logic [15:0] flash_rdata_i,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic [9:0]  rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic [7:0]  uart_wdata_o,
    input  logic [7:0]  uart_rdata_i,
    output logic        uart_rd_o,
    output logic        uart_wr_o,
    input  logic        uart_rx_ready_i,
    input  logic        uart_tx_busy_i
);

    // The 4-bit counter cannot represent longer waits.
    generate
        if (SRAM_WAIT < 0 || SRAM_WAIT > 7 ||
            FLASH_WAIT < 1 || FLASH_WAIT > 15) begin : g_bad_wait
            $error("mem_ctrl: wait-state parameter out of range");
        end
    endgenerate

    memctl_state_t state;
    memctl_state_t state_nxt;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic        accept;
    logic        cnt_load;
    logic [3:0]  cnt_val;
    logic        cnt_zero;
    logic        uart_data;
    logic        uart_stat;
    logic        flash_hi;

    assign accept    = (state == MEMCTL_IDLE) & req_i & tlb_hit_i;
    assign uart_data = (addr_q == UART_DATA_PADDR);
    assign uart_stat = (addr_q == UART_STAT_PADDR);

    mem_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= MEMCTL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MEMCTL_IDLE: begin
                if (req_i && tlb_hit_i) begin
                    if (sram_ce_i) begin
                        state_nxt = MEMCTL_SRAM;
                    end else if (flash_ce_i) begin
`ifdef MEM_CTRL_FLASH_EN
                        state_nxt = we_i ? MEMCTL_DONE : MEMCTL_FLASH_LO;
`else
                        state_nxt = MEMCTL_DONE;
`endif
                    end else if (rom_ce_i) begin
                        state_nxt = MEMCTL_ROM;
                    end else if (serial_ce_i) begin
                        state_nxt = MEMCTL_UART;
                    end else begin
                        state_nxt = MEMCTL_DONE;
                    end
                end
            end
            MEMCTL_SRAM: begin
                if (cnt_zero) state_nxt = MEMCTL_DONE;
            end
`ifdef MEM_CTRL_FLASH_EN
            MEMCTL_FLASH_LO: begin
                if (cnt_zero) state_nxt = MEMCTL_FLASH_HI;
            end
            MEMCTL_FLASH_HI: begin
                if (cnt_zero) state_nxt = MEMCTL_DONE;
            end
`endif
            MEMCTL_ROM:  state_nxt = MEMCTL_DONE;
            MEMCTL_UART: state_nxt = MEMCTL_DONE;
            MEMCTL_DONE: state_nxt = MEMCTL_IDLE;
            default:     state_nxt = MEMCTL_IDLE;
        endcase
    end

    // Counter reloads on every state change with the new state's wait.
    always_comb begin
        cnt_load = (state_nxt != state);
        cnt_val  = 4'd0;
        unique case (state_nxt)
            MEMCTL_SRAM:     cnt_val = 4'(SRAM_WAIT);
            MEMCTL_FLASH_LO: cnt_val = 4'(FLASH_WAIT - 1);
            MEMCTL_FLASH_HI: cnt_val = 4'(FLASH_WAIT - 1);
            default:         cnt_val = 4'd0;
        endcase
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = 4'hF;
        flash_ce_n = 1'b1;
        flash_oe_n = 1'b1;
        uart_rd_o  = 1'b0;
        uart_wr_o  = 1'b0;
        flash_hi   = 1'b0;
        unique case (state)
            MEMCTL_SRAM: begin
                sram_ce_n = 1'b0;
                sram_be_n = ~sel_q;
                if (we_q == WriteEnable) begin
                    sram_we_n = cnt_zero;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
`ifdef MEM_CTRL_FLASH_EN
            MEMCTL_FLASH_LO: begin
                flash_ce_n = 1'b0;
                flash_oe_n = 1'b0;
            end
            MEMCTL_FLASH_HI: begin
                flash_ce_n = 1'b0;
                flash_oe_n = 1'b0;
                flash_hi   = 1'b1;
            end
`endif
            MEMCTL_UART: begin
                uart_rd_o = uart_data & ~we_q;
                uart_wr_o = uart_data & we_q;
            end
            default: ;
        endcase
    end

    assign ready_o      = (state == MEMCTL_DONE);
    assign tlb_miss_o   = (state == MEMCTL_IDLE) & req_i & ~tlb_hit_i;
    assign stall_req_o  = accept |
                          ((state != MEMCTL_IDLE) && (state != MEMCTL_DONE));
    assign sram_addr_o  = addr_q[21:2];
    assign sram_wdata_o = data_q;
    assign flash_addr_o = {addr_q[22:2], flash_hi, 1'b0};
    assign uart_wdata_o = data_q[7:0];
    // ROM is synchronous: present the live address in the accept cycle.
    assign rom_addr_o   = ((state == MEMCTL_IDLE) && req_i) ?
                          addr_i[11:2] : addr_q[11:2];

`ifndef MEM_CTRL_FLASH_EN
    logic unused_flash;
    assign unused_flash = ^flash_rdata_i;
`endif

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            addr_q <= ZeroWord;
            data_q <= ZeroWord;
            sel_q  <= 4'h0;
            we_q   <= 1'b0;
            data_o <= ZeroWord;
        end else begin
            if (accept) begin
                addr_q <= addr_i;
                data_q <= data_i;
                sel_q  <= sel_i;
                we_q   <= we_i;
                data_o <= ZeroWord;
            end
            unique case (state)
                MEMCTL_SRAM: begin
                    if (cnt_zero && we_q != WriteEnable) begin
                        data_o <= sram_rdata_i;
                    end
                end
`ifdef MEM_CTRL_FLASH_EN
                MEMCTL_FLASH_LO: begin
                    if (cnt_zero) data_o[15:0] <= flash_rdata_i;
                end
                MEMCTL_FLASH_HI: begin
                    if (cnt_zero) data_o[31:16] <= flash_rdata_i;
                end
`endif
                MEMCTL_ROM: begin
                    if (we_q != WriteEnable) data_o <= rom_data_i;
                end
                MEMCTL_UART: begin
                    if (we_q != WriteEnable) begin
                        if (uart_data) begin
                            data_o <= {24'b0, uart_rdata_i};
                        end else if (uart_stat) begin
                            data_o <= uart_status(uart_rx_ready_i,
                                                  uart_tx_busy_i);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl (SRAM_WAIT=1, FLASH_WAIT=4).
// Flash expectations follow MEM_CTRL_FLASH_EN.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic        tlb_hit_i = 1'b0;
    logic        sram_ce_i = 1'b0;
    logic        flash_ce_i = 1'b0;
    logic        rom_ce_i = 1'b0;
    logic        serial_ce_i = 1'b0;
    logic [31:0] data_o;
    logic        ready_o;
    logic        stall_req_o;
    logic        tlb_miss_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i = 32'hDEAD_BEEF;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;
    logic [22:0] flash_addr_o;
    logic [15:0] flash_rdata_i;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic [9:0]  rom_addr_o;
    logic [31:0] rom_data_i = 32'h0;
    logic [7:0]  uart_wdata_o;
    logic [7:0]  uart_rdata_i = 8'h5A;
    logic        uart_rd_o;
    logic        uart_wr_o;
    logic        uart_rx_ready_i = 1'b1;
    logic        uart_tx_busy_i = 1'b1;

    mem_ctrl #(.SRAM_WAIT(1), .FLASH_WAIT(4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
        .sel_i(sel_i), .addr_i(addr_i), .data_i(data_i),
        .tlb_hit_i(tlb_hit_i), .sram_ce_i(sram_ce_i),
        .flash_ce_i(flash_ce_i), .rom_ce_i(rom_ce_i),
        .serial_ce_i(serial_ce_i), .data_o(data_o),
        .ready_o(ready_o), .stall_req_o(stall_req_o),
        .tlb_miss_o(tlb_miss_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
        .flash_addr_o(flash_addr_o), .flash_rdata_i(flash_rdata_i),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .uart_wdata_o(uart_wdata_o), .uart_rdata_i(uart_rdata_i),
        .uart_rd_o(uart_rd_o), .uart_wr_o(uart_wr_o),
        .uart_rx_ready_i(uart_rx_ready_i),
        .uart_tx_busy_i(uart_tx_busy_i)
    );

    always #5 clk = ~clk;

    // Flash device: low half 0xBEEF, high half 0xCAFE.
    assign flash_rdata_i = flash_addr_o[1] ? 16'hCAFE : 16'hBEEF;

    // Synchronous ROM model with one-cycle read latency.
    always @(posedge clk) rom_data_i <= 32'hA5A5_0000 | 32'(rom_addr_o);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got ready_o=1 want 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, data_o, e.data);
                check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                check({e.name, "_stall_done"}, 32'(stall_req_o), 32'd0);
            end
        end
    end

    int oe_low, we_low, fl_cnt, wr_cnt, rd_cnt;
    logic [19:0] seen_saddr;
    logic [3:0]  seen_be_n;
    logic [31:0] seen_wdata;
    logic [22:0] first_fa, last_fa;
    logic [7:0]  seen_uw;

    always @(negedge clk) begin
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (!sram_ce_n) begin
            seen_saddr = sram_addr_o;
            seen_be_n  = sram_be_n;
            seen_wdata = sram_wdata_o;
        end
        if (!flash_oe_n) begin
            if (fl_cnt == 0) first_fa = flash_addr_o;
            last_fa = flash_addr_o;
            fl_cnt++;
        end
        if (uart_wr_o) begin
            wr_cnt++;
            seen_uw = uart_wdata_o;
        end
        if (uart_rd_o) rd_cnt++;
    end

    task automatic clear_obs();
        oe_low = 0; we_low = 0; fl_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        seen_saddr = '0; seen_be_n = 4'hF; seen_wdata = '0;
        first_fa = '0; last_fa = '0; seen_uw = '0;
    endtask

    // ce = {sram, flash, rom, serial}
    task automatic do_req(input string name, input logic we,
                          input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] ce,
                          input logic [31:0] exp_data, input int exp_lat);
        exp_t e;
        int n;
        @(negedge clk);
        clear_obs();
        e.name = name; e.data = exp_data; e.lat = exp_lat; e.acc = cyc;
        sb.push_back(e);
        req_i = 1'b1; we_i = we; sel_i = sel; addr_i = addr;
        data_i = data; tlb_hit_i = 1'b1;
        {sram_ce_i, flash_ce_i, rom_ce_i, serial_ce_i} = ce;
        #1;
        check({name, "_stall_acc"}, 32'(stall_req_o), 32'd1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            #1;
            if (ready_o) break;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready_o want ready_o", name);
            void'(sb.pop_front());
        end
        req_i = 1'b0; we_i = 1'b0; tlb_hit_i = 1'b0;
        {sram_ce_i, flash_ce_i, rom_ce_i, serial_ce_i} = 4'b0000;
    endtask

    initial begin
        clear_obs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_data", data_o, 32'h0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_stall", 32'(stall_req_o), 32'd0);
        check("rst_miss", 32'(tlb_miss_o), 32'd0);
        check("rst_sram_n", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, 1'b1},
              32'hF);
        check("rst_be_n", 32'(sram_be_n), 32'hF);
        check("rst_flash_n", {30'h0, flash_ce_n, flash_oe_n}, 32'h3);
        check("rst_uart", {30'h0, uart_rd_o, uart_wr_o}, 32'h0);
        check("rst_addr", 32'(sram_addr_o), 32'h0);
        check("rst_wdata", sram_wdata_o, 32'h0);

        do_req("sram_rd", 1'b0, 4'hF, 32'h0000_0100, 32'h0, 4'b1000,
               32'hDEAD_BEEF, 3);
        check("sram_rd_addr", 32'(seen_saddr), 32'h40);
        check("sram_rd_oe", 32'(oe_low), 32'd2);

        do_req("sram_wr", 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678,
               4'b1000, 32'h0, 3);
        check("sram_wr_be", 32'(seen_be_n), 32'hC);
        check("sram_wr_we", 32'(we_low), 32'd1);
        check("sram_wr_wdata", seen_wdata, 32'h1234_5678);

`ifdef MEM_CTRL_FLASH_EN
        do_req("flash_rd", 1'b0, 4'hF, 32'h1E00_0004, 32'h0, 4'b0100,
               32'hCAFE_BEEF, 9);
        check("flash_fa_lo", 32'(first_fa), 32'h4);
        check("flash_fa_hi", 32'(last_fa), 32'h6);
        check("flash_cycles", 32'(fl_cnt), 32'd8);
`else
        do_req("flash_rd", 1'b0, 4'hF, 32'h1E00_0004, 32'h0, 4'b0100,
               32'h0, 1);
        check("flash_cycles", 32'(fl_cnt), 32'd0);
`endif

        do_req("uart_stat", 1'b0, 4'hF, 32'h1FD0_03FC, 32'h0, 4'b0001,
               32'h2, 2);
        do_req("uart_rd", 1'b0, 4'hF, 32'h1FD0_03F8, 32'h0, 4'b0001,
               32'h5A, 2);
        check("uart_rd_pulses", 32'(rd_cnt), 32'd1);
        do_req("uart_wr", 1'b1, 4'h1, 32'h1FD0_03F8, 32'h41, 4'b0001,
               32'h0, 2);
        check("uart_wr_pulses", 32'(wr_cnt), 32'd1);
        check("uart_wdata", 32'(seen_uw), 32'h41);

        do_req("no_dev", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 4'b0000,
               32'h0, 1);

        @(negedge clk);
        req_i = 1'b1; tlb_hit_i = 1'b0; sram_ce_i = 1'b1;
        addr_i = 32'h0000_0300;
        #1;
        check("miss_flag", 32'(tlb_miss_o), 32'd1);
        check("miss_stall", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        #1;
        check("miss_idle_flag", 32'(tlb_miss_o), 32'd1);
        check("miss_idle_stall", 32'(stall_req_o), 32'd0);
        req_i = 1'b0; sram_ce_i = 1'b0;

        @(negedge clk);
        req_i = 1'b1; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; we_i = 1'b0;
        addr_i = 32'h0000_0400;
        @(negedge clk);
        req_i = 1'b0; tlb_hit_i = 1'b0; sram_ce_i = 1'b0;
        #1;
        check("abort_ce_busy", 32'(sram_ce_n), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("abort_stall", 32'(stall_req_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        do_req("rom_rd", 1'b0, 4'hF, 32'h0000_0010, 32'h0, 4'b0010,
               32'hA5A5_0004, 2);
        do_req("sram_b2b", 1'b0, 4'hF, 32'h0000_0008, 32'h0, 4'b1000,
               32'hDEAD_BEEF, 3);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
